inst_packer: RTL

Instruction field packer for the pipelined CPU's instruction-memory loader path. Accepts decoded MIPS fields (opcode, register numbers, shift amount, function, immediate, jump index) plus a format select and assembles them into 32-bit instruction words. It buffers the words in a small FIFO and presents them with a word address to the instruction-memory write port.

---
 rtl/inst_packer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/inst_packer.sv
// -----------------------------------------------------------------------------
// inst_packer
// Packs decoded MIPS instruction fields into 32-bit words, buffers them in a
// small FIFO and presents each word with its word address to the
// instruction-memory write port.
//
// Parameters
//   DEPTH   FIFO entries (power of two, >= 2)
//   ADDR_W  width of the word-address counter (wraps silently)
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   flush             synchronous clear of FIFO, address and error flag
//   in_valid/in_ready field-set handshake (in_ready from registered count)
//   fmt               00 R, 01 I, 10 J, 11 illegal
//   op,rs,rt,rd,shamt,func,imm,index  instruction fields
//   out_valid/out_ready  head-word handshake
//   out_data          head word (0 when empty)
//   out_addr          word address of the head word
//   count             FIFO occupancy
//   err               sticky illegal-format flag
//
// Optional feature: define INST_PACK_CHECK_EN to drop fmt=11 words and raise
// the sticky err flag. Without it, fmt=11 packs as R-type and err is 0.
// -----------------------------------------------------------------------------
module inst_packer #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [1:0]                 fmt,
   input  logic [5:0]                 op,
   input  logic [4:0]                 rs,
   input  logic [4:0]                 rt,
   input  logic [4:0]                 rd,
   input  logic [4:0]                 shamt,
   input  logic [5:0]                 func,
   input  logic [15:0]                imm,
   input  logic [31:0]                index,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [31:0]                out_data,
   output logic [ADDR_W-1:0]          out_addr,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       err
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [31:0]       mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       word_d;
   logic              push_hs, pop_hs, wr_en;

   // Jump targets only carry 26 bits; the upper index bits are don't-care.
   logic              unused_index_hi;
   assign unused_index_hi = ^index[31:26];

   assign in_ready  = (count_q < CNT_W'(DEPTH));
   assign out_valid = (count_q != '0);
   assign out_data  = out_valid ? mem_q[rd_ptr_q] : 32'h0;
   assign out_addr  = addr_q;
   assign count     = count_q;

   assign push_hs = in_valid & in_ready;
   assign pop_hs  = out_valid & out_ready;

   always_comb begin
      word_d = {op, rs, rt, rd, shamt, func};
      case (fmt)
         2'b01:   word_d = {op, rs, rt, imm};
         2'b10:   word_d = {op, index[25:0]};
         default: word_d = {op, rs, rt, rd, shamt, func};
      endcase
   end

`ifdef INST_PACK_CHECK_EN
   logic err_q;
   logic illegal;

   // An illegal field set still completes its handshake but is never stored.
   assign illegal = push_hs & (fmt == 2'b11);
   assign wr_en   = push_hs & (fmt != 2'b11) & ~flush;
   assign err     = err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (flush) begin
         err_q <= 1'b0;
      end else if (illegal) begin
         err_q <= 1'b1;
      end
   end
`else
   assign wr_en = push_hs & ~flush;
   assign err   = 1'b0;
`endif

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      addr_d   = addr_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         addr_d   = '0;
      end else begin
         if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (pop_hs) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            addr_d   = addr_q + ADDR_W'(1);
         end
         count_d = count_q + CNT_W'(wr_en) - CNT_W'(pop_hs);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         addr_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         addr_q   <= addr_d;
      end
   end

   // Storage needs no reset: entries are only visible through count_q.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= word_d;
      end
   end

endmodule
